ni_uplink_arbiter: RTL

- Shares one router injection port between NUM_REQ network interfaces of a leaf group (4 GPUs per 2-bit leaf field).
- Sits between the NI GPU→router outputs and a single router input port.
- Round-robin arbitration with bounded burst lock and a one-entry output register.
- Single-flit packets; flits pass through unmodified.

---
 rtl/ni_uplink_arbiter_pkg.sv | 29 ++
 rtl/ni_uplink_arbiter_rr_priority_pick.sv | 27 ++
 rtl/ni_uplink_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ni_uplink_arbiter_pkg.sv
// Shared definitions for the NI uplink arbiter: flit layout, defaults and FSM encoding.
package ni_uplink_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned HEADER_W    = 6;
  localparam int unsigned PAYLOAD_W   = DATA_W - HEADER_W;

  // Routing header field positions inside a flit
  localparam int unsigned GROUP_HI_MSB = 15;
  localparam int unsigned GROUP_HI_LSB = 14;
  localparam int unsigned GROUP_LO_MSB = 13;
  localparam int unsigned GROUP_LO_LSB = 12;
  localparam int unsigned LEAF_MSB     = 11;
  localparam int unsigned LEAF_LSB     = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [1:0]           group_hi;
    logic [1:0]           group_lo;
    logic [1:0]           leaf;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

endpackage

// File: rtl/ni_uplink_arbiter_rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after start, modulo N.
module ni_uplink_arbiter_rr_priority_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from farthest to nearest so the closest candidate to start wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req[IDX_W'(start + IDX_W'(k))]) begin
        idx = IDX_W'(start + IDX_W'(k));
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/ni_uplink_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one router injection port
// between NUM_REQ network interfaces; one-entry registered output stage.
module ni_uplink_arbiter
  import ni_uplink_arbiter_pkg::arb_state_e,
         ni_uplink_arbiter_pkg::ST_IDLE,
         ni_uplink_arbiter_pkg::ST_LOCK,
         ni_uplink_arbiter_pkg::NUM_REQ_DEF;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned DATA_W    = ni_uplink_arbiter_pkg::DATA_W,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         router_data_out,
  output logic                      router_valid_out,
  input  logic                      router_ready_in,
  output logic [IDX_W-1:0]          owner_id
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;

  logic               can_load;
  logic [IDX_W-1:0]   start;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [CNT_W-1:0]   cnt_inc;
  logic               idle_accept;

  assign can_load = !valid_q || router_ready_in;

  // Starting the search at the owner keeps it first while valid, else falls to owner+1.
  assign start = (state_q == ST_LOCK) ? owner_q : rr_ptr_q;

  ni_uplink_arbiter_rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_priority_pick (
    .req   (req_valid),
    .start (start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready        = (reset && can_load) ? pick_grant : '0;
  assign router_data_out  = data_q;
  assign router_valid_out = valid_q;
  assign owner_id         = owner_q;

  // Next-state logic; everything holds while the output stage is stalled.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    cnt_inc     = burst_cnt_q + CNT_W'(1);
    idle_accept = 1'b0;
    if (can_load) begin
      unique case (state_q)
        ST_IDLE: idle_accept = pick_any;
        ST_LOCK: begin
          if (pick_any && (pick_idx == owner_q)) begin
            burst_cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(MAX_BURST)) begin
              rr_ptr_d    = owner_q + IDX_W'(1);
              burst_cnt_d = '0;
              owner_d     = '0;
              state_d     = ST_IDLE;
            end
          end else begin
            rr_ptr_d    = owner_q + IDX_W'(1);
            burst_cnt_d = '0;
            owner_d     = '0;
            state_d     = ST_IDLE;
            idle_accept = pick_any;
          end
        end
        default: ;
      endcase
      if (idle_accept) begin
        if (MAX_BURST == 1) begin
          rr_ptr_d = pick_idx + IDX_W'(1);
        end else begin
          state_d     = ST_LOCK;
          owner_d     = pick_idx;
          burst_cnt_d = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // One-entry output register toward the router.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (can_load) begin
      valid_q <= pick_any;
      if (pick_any) data_q <= req_data[pick_idx*DATA_W +: DATA_W];
    end
  end

endmodule
